// File: rtl/alu_issue_stage_if.sv
// ALU operand bus between the issue stage (master) and the execute stage (slave).
interface alu_issue_stage_if #(
    parameter int DATA_W = 32
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [3:0]        alu_ctrl;
    logic [4:0]        rd;
    logic              wb_en;
    logic              mem_rd;
    logic              mem_wr;
    logic [2:0]        mem_funct3;
    logic              illegal;

    modport master (
        output out_valid, alu_a, alu_b, alu_ctrl, rd, wb_en, mem_rd, mem_wr, mem_funct3, illegal,
        input  out_ready
    );

    modport slave (
        input  out_valid, alu_a, alu_b, alu_ctrl, rd, wb_en, mem_rd, mem_wr, mem_funct3, illegal,
        output out_ready
    );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I decode/issue into a one-entry registered slot feeding the ALU operand bus.
// Define ALU_ISSUE_PERF_EN to add issued_cnt / illegal_cnt handshake counters.
module alu_issue_stage #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [DATA_W-1:0] rs2_data,
    alu_issue_stage_if.master alu_o
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [31:0]       issued_cnt,
    output logic [15:0]       illegal_cnt
`endif
);

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011
    } opcode_e;

    typedef enum logic [3:0] {
        CTRL_LUI  = 4'b0000,
        CTRL_AGEN = 4'b0001,
        CTRL_ADD  = 4'b0010,
        CTRL_XOR  = 4'b0011,
        CTRL_OR   = 4'b0100,
        CTRL_AND  = 4'b0101,
        CTRL_SLL  = 4'b0110,
        CTRL_SRL  = 4'b0111,
        CTRL_SRA  = 4'b1000,
        CTRL_SUB  = 4'b1001,
        CTRL_SLT  = 4'b1010,
        CTRL_SLTU = 4'b1011
    } alu_ctrl_e;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        alu_ctrl_e         ctrl;
        logic [4:0]        rd;
        logic              wb_en;
        logic              mem_rd;
        logic              mem_wr;
        logic [2:0]        funct3;
        logic              illegal;
    } entry_t;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [DATA_W-1:0] imm_i;
    logic [DATA_W-1:0] imm_s;
    logic [DATA_W-1:0] shamt_imm;
    logic [DATA_W-1:0] shamt_reg;
    logic              legal;
    logic              accept;
    logic              valid_d;
    logic              valid_q;
    entry_t            entry_d;
    entry_t            entry_q;
    logic              unused_rs1_field;

    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7    = instr[31:25];
    assign imm_i     = {{(DATA_W-12){instr[31]}}, instr[31:20]};
    assign imm_s     = {{(DATA_W-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign shamt_imm = DATA_W'(instr[24:20]);
    // Register shift amounts are masked here because the ALU shifts by the whole of B.
    assign shamt_reg = DATA_W'(rs2_data[SHAMT_W-1:0]);
    assign unused_rs1_field = ^instr[19:15];

    always_comb begin
        // NOTE: every field gets a default first so no path through the case infers a latch.
        entry_d        = '0;
        entry_d.ctrl   = CTRL_ADD;
        entry_d.rd     = instr[11:7];
        entry_d.funct3 = funct3;
        legal          = 1'b0;
        case (opcode)
            OPC_LUI: begin
                legal         = 1'b1;
                entry_d.ctrl  = CTRL_LUI;
                entry_d.b     = DATA_W'(instr[31:12]);
                entry_d.wb_en = 1'b1;
            end
            OPC_LOAD: begin
                legal          = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
                entry_d.ctrl   = CTRL_AGEN;
                entry_d.a      = rs1_data;
                entry_d.b      = imm_i;
                entry_d.mem_rd = 1'b1;
                entry_d.wb_en  = 1'b1;
            end
            OPC_STORE: begin
                legal          = funct3 inside {3'b000, 3'b001, 3'b010};
                entry_d.ctrl   = CTRL_AGEN;
                entry_d.a      = rs1_data;
                entry_d.b      = imm_s;
                entry_d.mem_wr = 1'b1;
            end
            OPC_OP_IMM: begin
                legal         = 1'b1;
                entry_d.a     = rs1_data;
                entry_d.b     = imm_i;
                entry_d.wb_en = 1'b1;
                case (funct3)
                    3'b000:  entry_d.ctrl = CTRL_ADD;
                    3'b010:  entry_d.ctrl = CTRL_SLT;
                    3'b011:  entry_d.ctrl = CTRL_SLTU;
                    3'b100:  entry_d.ctrl = CTRL_XOR;
                    3'b110:  entry_d.ctrl = CTRL_OR;
                    3'b111:  entry_d.ctrl = CTRL_AND;
                    3'b001: begin
                        legal        = (funct7 == 7'b0000000);
                        entry_d.ctrl = CTRL_SLL;
                        entry_d.b    = shamt_imm;
                    end
                    default: begin
                        legal        = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                        entry_d.ctrl = funct7[5] ? CTRL_SRA : CTRL_SRL;
                        entry_d.b    = shamt_imm;
                    end
                endcase
            end
            OPC_OP: begin
                legal         = 1'b1;
                entry_d.a     = rs1_data;
                entry_d.b     = (funct3 == 3'b001 || funct3 == 3'b101) ? shamt_reg : rs2_data;
                entry_d.wb_en = 1'b1;
                case ({funct7, funct3})
                    10'b0000000_000: entry_d.ctrl = CTRL_ADD;
                    10'b0000000_001: entry_d.ctrl = CTRL_SLL;
                    10'b0000000_010: entry_d.ctrl = CTRL_SLT;
                    10'b0000000_011: entry_d.ctrl = CTRL_SLTU;
                    10'b0000000_100: entry_d.ctrl = CTRL_XOR;
                    10'b0000000_101: entry_d.ctrl = CTRL_SRL;
                    10'b0000000_110: entry_d.ctrl = CTRL_OR;
                    10'b0000000_111: entry_d.ctrl = CTRL_AND;
                    10'b0100000_000: entry_d.ctrl = CTRL_SUB;
                    10'b0100000_101: entry_d.ctrl = CTRL_SRA;
                    default:         legal        = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase

        // Illegal entries still flow downstream, as a harmless ADD 0+0 with no side effects.
        if (!legal) begin
            entry_d.a       = '0;
            entry_d.b       = '0;
            entry_d.ctrl    = CTRL_ADD;
            entry_d.wb_en   = 1'b0;
            entry_d.mem_rd  = 1'b0;
            entry_d.mem_wr  = 1'b0;
            entry_d.illegal = 1'b1;
        end
        if (entry_d.rd == 5'd0) begin
            entry_d.wb_en = 1'b0;
        end
    end

    assign in_ready = !valid_q || alu_o.out_ready;
    assign accept   = in_valid && in_ready;
    assign valid_d  = flush ? 1'b0 : (accept ? 1'b1 : (valid_q && !alu_o.out_ready));

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
        if (rst) begin
            valid_q <= 1'b0;
            entry_q <= '0;
        end else begin
            valid_q <= valid_d;
            if (accept && !flush) begin
                entry_q <= entry_d;
            end
        end
    end

    assign alu_o.out_valid  = valid_q;
    assign alu_o.alu_a      = entry_q.a;
    assign alu_o.alu_b      = entry_q.b;
    assign alu_o.alu_ctrl   = entry_q.ctrl;
    assign alu_o.rd         = entry_q.rd;
    assign alu_o.wb_en      = entry_q.wb_en;
    assign alu_o.mem_rd     = entry_q.mem_rd;
    assign alu_o.mem_wr     = entry_q.mem_wr;
    assign alu_o.mem_funct3 = entry_q.funct3;
    assign alu_o.illegal    = entry_q.illegal;

`ifdef ALU_ISSUE_PERF_EN
    logic        handshake;
    logic [31:0] issued_q;
    logic [15:0] illegal_q;

    // A handshake coinciding with flush is a killed entry and is not counted.
    assign handshake = valid_q && alu_o.out_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            issued_q  <= '0;
            illegal_q <= '0;
        end else if (handshake) begin
            issued_q <= issued_q + 32'd1;
            if (entry_q.illegal && illegal_q != 16'hFFFF) begin
                illegal_q <= illegal_q + 16'd1;
            end
        end
    end

    assign issued_cnt  = issued_q;
    assign illegal_cnt = illegal_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed vector table, corner sequences, random vs model.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] issued_cnt;
    logic [15:0] illegal_cnt;
`endif

    always #5 clk = ~clk;

    alu_issue_stage_if #(.DATA_W(32)) bus ();

    alu_issue_stage #(.DATA_W(32), .SHAMT_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .instr    (instr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .alu_o    (bus)
`ifdef ALU_ISSUE_PERF_EN
        ,
        .issued_cnt  (issued_cnt),
        .illegal_cnt (illegal_cnt)
`endif
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        wb;
        logic        mrd;
        logic        mwr;
        logic [2:0]  f3;
        logic        ill;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        wb;
        logic        mrd;
        logic        mwr;
        logic        ill;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    logic m_valid  = 1'b0;
    logic m_known  = 1'b0;
    exp_t m_e      = '0;
    int   m_iss    = 0;
    int   m_ill    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode from the instruction-set rules, using lookup tables per class.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
        exp_t       e;
        int         code;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        int         imm_codes[8];
        int         reg_codes[8];
        imm_codes = '{2, -1, 10, 11, 3, -1, 4, 5};
        reg_codes = '{2, 6, 10, 11, 3, 7, 4, 5};
        e    = '0;
        op   = ins[6:0];
        f3   = ins[14:12];
        f7   = ins[31:25];
        code = -1;
        e.rd = ins[11:7];
        e.f3 = f3;
        if (op == 7'h37) begin
            code = 0;
            e.b  = ins >> 12;
            e.wb = 1'b1;
        end else if (op == 7'h03 && f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin
            code  = 1;
            e.a   = r1;
            e.b   = 32'($signed(ins[31:20]));
            e.mrd = 1'b1;
            e.wb  = 1'b1;
        end else if (op == 7'h23 && f3 <= 3'd2) begin
            code  = 1;
            e.a   = r1;
            e.b   = 32'($signed({ins[31:25], ins[11:7]}));
            e.mwr = 1'b1;
        end else if (op == 7'h13) begin
            e.a  = r1;
            e.wb = 1'b1;
            if (f3 == 3'd1 || f3 == 3'd5) begin
                e.b = 32'(ins[24:20]);
                if (f3 == 3'd1 && f7 == 7'd0) code = 6;
                else if (f3 == 3'd5 && f7 == 7'd0) code = 7;
                else if (f3 == 3'd5 && f7 == 7'h20) code = 8;
            end else begin
                e.b  = 32'($signed(ins[31:20]));
                code = imm_codes[f3];
            end
        end else if (op == 7'h33) begin
            e.a  = r1;
            e.wb = 1'b1;
            e.b  = (f3 == 3'd1 || f3 == 3'd5) ? (r2 % 32) : r2;
            if (f7 == 7'd0) code = reg_codes[f3];
            else if (f7 == 7'h20 && f3 == 3'd0) code = 9;
            else if (f7 == 7'h20 && f3 == 3'd5) code = 8;
        end
        if (code < 0) begin
            e.a    = '0;
            e.b    = '0;
            e.wb   = 1'b0;
            e.mrd  = 1'b0;
            e.mwr  = 1'b0;
            e.ill  = 1'b1;
            e.ctrl = 4'd2;
        end else begin
            e.ctrl = 4'(code);
        end
        if (e.rd == 5'd0) e.wb = 1'b0;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  ops[8];
        int          k;
        ops = '{7'h37, 7'h03, 7'h23, 7'h13, 7'h33, 7'h33, 7'h13, 7'h63};
        w = $urandom();
        k = $urandom_range(0, 9);
        if (k < 8) w[6:0] = ops[k];
        if (w[6:0] == 7'h33 || w[6:0] == 7'h13) begin
            case ($urandom_range(0, 3))
                0, 1:    w[31:25] = 7'h00;
                2:       w[31:25] = 7'h20;
                default: ;
            endcase
        end
        return w;
    endfunction

    task automatic compare_outputs();
        check("out_valid", bus.out_valid, m_valid);
        if (m_valid || m_known) begin
            check("alu_a", bus.alu_a, m_e.a);
            check("alu_b", bus.alu_b, m_e.b);
            check("ctrl_rd_flags",
                  {bus.alu_ctrl, bus.rd, bus.wb_en, bus.mem_rd, bus.mem_wr, bus.mem_funct3, bus.illegal},
                  {m_e.ctrl, m_e.rd, m_e.wb, m_e.mrd, m_e.mwr, m_e.f3, m_e.ill});
        end
`ifdef ALU_ISSUE_PERF_EN
        check("issued_cnt", issued_cnt, 32'(m_iss));
        check("illegal_cnt", illegal_cnt, 16'(m_ill));
`endif
    endtask

    // One clock: check in_ready, advance the model across the edge, then compare outputs.
    task automatic tick();
        exp_t nxt;
        logic acc;
        #1;
        check("in_ready", in_ready, !m_valid || bus.out_ready);
        nxt = ref_decode(instr, rs1_data, rs2_data);
        acc = in_valid && (!m_valid || bus.out_ready);
        if (!rst && !flush && m_valid && bus.out_ready) begin
            m_iss++;
            if (m_e.ill && m_ill < 65535) m_ill++;
        end
        if (rst) begin
            m_valid = 1'b0;
            m_known = 1'b1;
            m_e     = '0;
            m_iss   = 0;
            m_ill   = 0;
        end else if (flush) begin
            m_valid = 1'b0;
            m_known = 1'b0;
        end else if (acc) begin
            m_valid = 1'b1;
            m_known = 1'b1;
            m_e     = nxt;
        end else if (bus.out_ready) begin
            m_valid = 1'b0;
            m_known = 1'b0;
        end
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic set_in(input logic v, input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
        in_valid = v;
        instr    = ins;
        rs1_data = r1;
        rs2_data = r2;
    endtask

    vec_t vecs[$];
    int   ill_base;

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        bus.out_ready = 1'b0;
        set_in(1'b0, 32'h0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        tick();
        check("reset_ctrl", bus.alu_ctrl, 4'b0000);
        rst = 1'b0;

        vecs.push_back('{"addi",     32'hFFF08293, 32'h10,       32'h0,        4'b0010, 32'h10,       32'hFFFFFFFF, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"lui",      32'hABCDE1B7, 32'h12345678, 32'h0,        4'b0000, 32'h0,        32'h000ABCDE, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"sra",      32'h40615233, 32'h80000000, 32'h00000124, 4'b1000, 32'h80000000, 32'h4,        5'd4,  1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"sub_x0",   32'h40208033, 32'h50,       32'h7,        4'b1001, 32'h50,       32'h7,        5'd0,  1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"sw",       32'h0020A423, 32'h100,      32'h55,       4'b0001, 32'h100,      32'h8,        5'd8,  1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"sw_neg",   32'hFE20AE23, 32'h200,      32'h0,        4'b0001, 32'h200,      32'hFFFFFFFC, 5'd28, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"lw",       32'h00412303, 32'h1000,     32'h0,        4'b0001, 32'h1000,     32'h4,        5'd6,  1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"slli",     32'h01F09093, 32'h1,        32'h0,        4'b0110, 32'h1,        32'h1F,       5'd1,  1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"srai",     32'h4010D093, 32'h9,        32'h0,        4'b1000, 32'h9,        32'h1,        5'd1,  1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"sll_mask", 32'h002090B3, 32'h3,        32'hFFFFFFE3, 4'b0110, 32'h3,        32'h3,        5'd1,  1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"beq",      32'h00208463, 32'h11,       32'h22,       4'b0010, 32'h0,        32'h0,        5'd8,  1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"mul",      32'h022082B3, 32'h11,       32'h22,       4'b0010, 32'h0,        32'h0,        5'd5,  1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"srli_bad", 32'h0210D093, 32'h11,       32'h0,        4'b0010, 32'h0,        32'h0,        5'd1,  1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"ld",       32'h0000B183, 32'h11,       32'h0,        4'b0010, 32'h0,        32'h0,        5'd3,  1'b0, 1'b0, 1'b0, 1'b1});

        bus.out_ready = 1'b1;
        foreach (vecs[i]) begin
            set_in(1'b1, vecs[i].ins, vecs[i].r1, vecs[i].r2);
            tick();
            check({"vec_valid_", vecs[i].name}, bus.out_valid, 1'b1);
            check({"vec_ctrl_", vecs[i].name}, bus.alu_ctrl, vecs[i].ctrl);
            check({"vec_a_", vecs[i].name}, bus.alu_a, vecs[i].a);
            check({"vec_b_", vecs[i].name}, bus.alu_b, vecs[i].b);
            check({"vec_flags_", vecs[i].name},
                  {bus.rd, bus.wb_en, bus.mem_rd, bus.mem_wr, bus.illegal},
                  {vecs[i].rd, vecs[i].wb, vecs[i].mrd, vecs[i].mwr, vecs[i].ill});
        end
        set_in(1'b0, 32'h0, 32'h0, 32'h0);
        tick();

        // Stall after a store, then release with a new instruction waiting.
        set_in(1'b1, 32'h0020A423, 32'h100, 32'h0);
        tick();
        set_in(1'b1, 32'hFFF08293, 32'h10, 32'h0);
        bus.out_ready = 1'b0;
        repeat (3) begin
            tick();
            check("stall_in_ready", in_ready, 1'b0);
            check("stall_b", bus.alu_b, 32'h8);
            check("stall_flags", {bus.alu_ctrl, bus.mem_wr, bus.wb_en}, {4'b0001, 1'b1, 1'b0});
        end
        bus.out_ready = 1'b1;
        tick();
        check("reload_valid", bus.out_valid, 1'b1);
        check("reload_rd", bus.rd, 5'd5);
        set_in(1'b0, 32'h0, 32'h0, 32'h0);
        tick();
        check("drain_valid", bus.out_valid, 1'b0);

        // Two illegal instructions pass through and are counted.
        ill_base = m_ill;
        set_in(1'b1, 32'h00208463, 32'h1, 32'h2);
        tick();
        set_in(1'b1, 32'h022082B3, 32'h1, 32'h2);
        tick();
        set_in(1'b0, 32'h0, 32'h0, 32'h0);
        tick();
`ifdef ALU_ISSUE_PERF_EN
        check("illegal_step2", illegal_cnt, 16'(ill_base + 2));
`endif

        // Flush while holding, with a new instruction offered the same cycle.
        set_in(1'b1, 32'h0020A423, 32'h100, 32'h0);
        tick();
        bus.out_ready = 1'b0;
        set_in(1'b1, 32'hABCDE1B7, 32'h0, 32'h0);
        flush = 1'b1;
        tick();
        check("flush_valid", bus.out_valid, 1'b0);
        flush = 1'b0;
        set_in(1'b0, 32'h0, 32'h0, 32'h0);
        tick();
        check("flush_dropped", bus.out_valid, 1'b0);

        // Reset in the middle of a stall.
        set_in(1'b1, 32'h0020A423, 32'h100, 32'h0);
        tick();
        set_in(1'b0, 32'h0, 32'h0, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_ctrl", bus.alu_ctrl, 4'b0000);
        rst = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            set_in($urandom_range(0, 3) != 0, rand_instr(), $urandom(), $urandom());
            bus.out_ready = $urandom_range(0, 2) != 0;
            flush         = $urandom_range(0, 15) == 0;
            rst           = $urandom_range(0, 199) == 0;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- RV32I decode/issue stage on the producer side of the ALU operand interface.
- Drives the ALU's A, B and 4-bit Control code from a fetched instruction and the register-file read data.
- Holds the result in a one-entry registered pipeline slot with valid/ready handshakes on both sides.
- Also flags the memory operation and the writeback target for downstream stages.

Parameters:
- DATA_W, 32: datapath width; must equal the ALU data width.
- SHAMT_W, 5: shift-amount bits passed to the ALU on B for shift ops.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  kill the held entry and any entry being accepted this cycle
- in_valid  in  1  instruction/operands valid
- in_ready  out  1  stage can accept
- instr  in  32  RV32I instruction word
- rs1_data  in  DATA_W  register-file read port 1
- rs2_data  in  DATA_W  register-file read port 2
- out_valid  out  1  issued entry valid
- out_ready  in  1  ALU/execute stage accepts
- alu_a  out  DATA_W  ALU operand A
- alu_b  out  DATA_W  ALU operand B
- alu_ctrl  out  4  ALU Control code
- rd  out  5  destination register
- wb_en  out  1  register writeback required
- mem_rd  out  1  load
- mem_wr  out  1  store
- mem_funct3  out  3  instr[14:12] for load/store sizing
- illegal  out  1  instruction unsupported or malformed

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0. All data outputs are 0, including alu_ctrl=4'b0000. Reset overrides flush and any accept.
- in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready.
- Latency: 1 cycle. An accepted instruction appears registered on the next edge.
- Stall: while out_valid && !out_ready, all outputs stay stable.
- Same-cycle accept and drain: when out_ready && out_valid && in_valid, the slot reloads without a bubble.
- Drain without accept: when out_ready && out_valid && !in_valid, out_valid goes to 0 next edge.
- Flush: out_valid goes to 0 next edge and the instruction presented that cycle is dropped. Flush has priority over accept. Data outputs may hold stale values.
- Decode is purely a function of instr, rs1_data and rs2_data captured at accept.
  - rd = instr[11:7].
  - imm_i = sext(instr[31:20]).
  - imm_s = sext({instr[31:25], instr[11:7]}).
- LUI (0110111): ctrl 0000, A=0, B={12'b0, instr[31:12]} (the ALU places B[19:0] into the upper 20 bits), wb.
- LOAD (0000011), funct3 in {000,001,010,100,101}: ctrl 0001, A=rs1, B=imm_i, mem_rd=1, wb.
- STORE (0100011), funct3 in {000,001,010}: ctrl 0001, A=rs1, B=imm_s, mem_wr=1, wb_en=0.
- OP-IMM (0010011): A=rs1 for all.
  - ADDI 0010, SLTI 1010, SLTIU 1011, XORI 0011, ORI 0100, ANDI 0101; B=imm_i.
  - SLLI 0110: requires instr[31:25]=0.
  - SRLI 0111: requires instr[31:25]=0000000.
  - SRAI 1000: requires instr[31:25]=0100000.
  - For all shifts, B = zero-extended instr[24:20].
- OP (0110011): A=rs1.
  - funct7 0000000: ADD 0010, SLL 0110, SLT 1010, SLTU 1011, XOR 0011, SRL 0111, OR 0100, AND 0101.
  - funct7 0100000: SUB 1001, SRA 1000.
  - B=rs2, except for shifts, where B = zero-extended rs2[SHAMT_W-1:0]. The ALU shifts by the full B, so masking is mandatory here.
- Illegal: any other opcode, funct3 or funct7 combination (including branch, JAL, JALR, AUIPC, SYSTEM, FENCE).
  - Outputs: illegal=1, ctrl=0010, A=0, B=0, wb_en=mem_rd=mem_wr=0.
  - The entry still flows through the handshake; the downstream trap logic handles it.
- wb_en is forced to 0 when rd=0.
- mem_funct3 always equals instr[14:12] of the held entry.

Optional Feature:
- Macro: ALU_ISSUE_PERF_EN
- When defined, the block adds two outputs:
  - issued_cnt (32 bits): increments once per out_valid && out_ready handshake.
  - illegal_cnt (16 bits): increments on handshakes where illegal=1; saturates at 16'hFFFF.
- Both counters are cleared by rst and are unaffected by flush. Flushed entries are never counted.
- When not defined, the ports and logic are absent. All other behaviour is identical.

Test Plan:
- ADDI x5,x1,-1 (instr 32'hFFF08293), rs1=32'h10, out_ready=1 -> next cycle: out_valid=1, alu_ctrl=0010, alu_a=32'h10, alu_b=32'hFFFFFFFF, rd=5, wb_en=1.
- LUI x3,0xABCDE (32'hABCDE1B7) -> alu_ctrl=0000, alu_a=0, alu_b=32'h000ABCDE, wb_en=1.
- SRA x4,x2,x6 (32'h40615233), rs2=32'h00000124 -> alu_ctrl=1000, alu_b=32'h00000004. Also check SUB (32'h40208033) -> ctrl 1001, wb_en=0 because rd=0.
- Hold out_ready=0 for 3 cycles after SW (32'h0020A423), rs1=32'h100 -> outputs stable at ctrl 0001, alu_b=8, mem_wr=1, wb_en=0, in_ready=0. Releasing out_ready with a new valid input -> back-to-back reload with no bubble.
- Opcode 1100011 (BEQ) and OP with funct7=0000001 -> illegal=1, ctrl=0010, A=B=0, wb_en=0. With ALU_ISSUE_PERF_EN, illegal_cnt steps by 2.
- Flush asserted together with in_valid while an entry is held -> out_valid=0 next cycle and the new instruction never appears. Asserting rst mid-stall -> out_valid=0, alu_ctrl=0000.
